// File: rtl/ps_fetch_seq.sv
// ps_fetch_seq: program-memory fetch address sequencer with an N-deep PC stack and a nested hardware-loop stack
// Ports:
//   clk_fetch, rst (async, active-low), stallb (0 freezes all state)
//   jmp_req/call_req/tgt_addr    : jump or call to tgt_addr (call pushes faddr)
//   rtrn_req, push_req/push_data, pop_req : PC stack return / explicit push / explicit pop
//   loop_req/loop_end/loop_cnt   : open a loop level starting at the current faddr
//   idle_req, interrupt          : enter / leave idle
//   faddr, pm_cslt               : fetch address and PM chip select
//   pcstk_top/pcstk_ptr, lp_lvl/lp_curcnt, stcky : stack status and sticky error flags
module ps_fetch_seq #(
    parameter int ADDR_W     = 16,
    parameter int PC_DEPTH   = 8,
    parameter int LOOP_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                        clk_fetch,
    input  logic                        rst,
    input  logic                        stallb,
    input  logic                        jmp_req,
    input  logic                        call_req,
    input  logic [ADDR_W-1:0]           tgt_addr,
    input  logic                        rtrn_req,
    input  logic                        push_req,
    input  logic                        pop_req,
    input  logic [ADDR_W-1:0]           push_data,
    input  logic                        loop_req,
    input  logic [ADDR_W-1:0]           loop_end,
    input  logic [CNT_W-1:0]            loop_cnt,
    input  logic                        idle_req,
    input  logic                        interrupt,
    output logic [ADDR_W-1:0]           faddr,
    output logic                        pm_cslt,
    output logic [ADDR_W-1:0]           pcstk_top,
    output logic [$clog2(PC_DEPTH):0]   pcstk_ptr,
    output logic [$clog2(LOOP_DEPTH):0] lp_lvl,
    output logic [CNT_W-1:0]            lp_curcnt,
    output logic [5:0]                  stcky
);
    localparam int PA = $clog2(PC_DEPTH);
    localparam int PW = PA + 1;
    localparam int LA = $clog2(LOOP_DEPTH);
    localparam int LW = LA + 1;

    logic [ADDR_W-1:0] r_faddr;
    logic [ADDR_W-1:0] r_pc_stk [PC_DEPTH];
    logic [PW-1:0]     r_pc_ptr;
    logic [ADDR_W-1:0] r_lp_start [LOOP_DEPTH];
    logic [ADDR_W-1:0] r_lp_end [LOOP_DEPTH];
    logic [CNT_W-1:0]  r_lp_cnt [LOOP_DEPTH];
    logic [LW-1:0]     r_lp_lvl;
    logic              r_idle, r_halt, r_pc_uo, r_lp_ovf;

    logic              w_run, w_jmp, w_pop_any;
    logic              w_pc_empty, w_pc_full, w_pc_push, w_pc_pop, w_pc_ovf, w_pc_unf, w_do_rtrn;
    logic [PA-1:0]     w_pc_tidx;
    logic [ADDR_W-1:0] w_pc_top;
    logic [PW-1:0]     w_pc_ptr_nxt;
    logic              w_lp_empty, w_lp_full, w_at_end, w_wrap, w_lp_fin, w_lp_ovf, w_lp_push;
    logic [LA-1:0]     w_lp_tidx;
    logic [ADDR_W-1:0] w_lp_end_top;
    logic [CNT_W-1:0]  w_lp_cnt_top, w_cnt_in;
    logic [LW-1:0]     w_lp_base;
    logic [ADDR_W-1:0] w_faddr_nxt;

    always_comb begin
        w_run        = stallb & !r_idle & !r_halt;
        w_jmp        = jmp_req | call_req;
        w_pop_any    = rtrn_req | pop_req;
        w_pc_empty   = r_pc_ptr == '0;
        w_pc_full    = r_pc_ptr == PW'(PC_DEPTH);
        w_pc_tidx    = PA'(r_pc_ptr - 1'b1);
        w_pc_top     = w_pc_empty ? '0 : r_pc_stk[w_pc_tidx];
        // A call always pushes; otherwise a simultaneous push and pop cancel out.
        w_pc_push    = call_req | (push_req & !w_pop_any);
        w_pc_pop     = !call_req & !push_req & w_pop_any;
        w_pc_ovf     = w_pc_push & w_pc_full;
        w_pc_unf     = w_pc_pop & w_pc_empty;
        w_do_rtrn    = !w_jmp & rtrn_req & !w_pc_empty;
        w_pc_ptr_nxt = (w_pc_push & !w_pc_full) ? r_pc_ptr + 1'b1 :
                       (w_pc_pop & !w_pc_empty) ? r_pc_ptr - 1'b1 : r_pc_ptr;
        w_lp_empty   = r_lp_lvl == '0;
        w_lp_full    = r_lp_lvl == LW'(LOOP_DEPTH);
        w_lp_tidx    = LA'(r_lp_lvl - 1'b1);
        w_lp_end_top = w_lp_empty ? '0 : r_lp_end[w_lp_tidx];
        w_lp_cnt_top = w_lp_empty ? '0 : r_lp_cnt[w_lp_tidx];
        // Only the innermost level is compared; any rtrn request suppresses the wrap.
        w_at_end     = !w_jmp & !rtrn_req & !w_lp_empty & (r_faddr == w_lp_end_top);
        w_wrap       = w_at_end & (w_lp_cnt_top > CNT_W'(1));
        w_lp_fin     = w_at_end & !w_wrap;
        // A level finishing this cycle frees its slot for a new loop_req.
        w_lp_base    = r_lp_lvl - LW'(w_lp_fin);
        w_lp_ovf     = loop_req & (w_lp_base == LW'(LOOP_DEPTH));
        w_lp_push    = loop_req & !w_lp_ovf;
        w_cnt_in     = (loop_cnt == '0) ? CNT_W'(1) : loop_cnt;
        w_faddr_nxt  = w_jmp ? tgt_addr : w_do_rtrn ? w_pc_top :
                       w_wrap ? r_lp_start[w_lp_tidx] : r_faddr + 1'b1;
    end

    always_ff @(posedge clk_fetch or negedge rst) begin
        if (!rst) begin
            r_faddr  <= '0;
            r_pc_ptr <= '0;
            r_lp_lvl <= '0;
            r_idle   <= 1'b0;
            r_halt   <= 1'b0;
            r_pc_uo  <= 1'b0;
            r_lp_ovf <= 1'b0;
        end else if (stallb) begin
            r_idle <= !interrupt & (r_idle | (idle_req & !r_halt));
            if (w_run) begin
                r_faddr  <= w_faddr_nxt;
                r_pc_ptr <= w_pc_ptr_nxt;
                r_lp_lvl <= w_lp_base + LW'(w_lp_push);
                r_pc_uo  <= r_pc_uo | w_pc_ovf | w_pc_unf;
                r_lp_ovf <= r_lp_ovf | w_lp_ovf;
                r_halt   <= r_halt | w_pc_ovf | w_lp_ovf;
            end
        end
    end

    // Stack storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk_fetch) begin
        if (rst && w_run) begin
            if (w_pc_push && !w_pc_full)
                r_pc_stk[r_pc_ptr[PA-1:0]] <= call_req ? r_faddr : push_data;
            if (w_wrap)
                r_lp_cnt[w_lp_tidx] <= w_lp_cnt_top - 1'b1;
            if (w_lp_push) begin
                r_lp_start[LA'(w_lp_base)] <= r_faddr;
                r_lp_end[LA'(w_lp_base)]   <= loop_end;
                r_lp_cnt[LA'(w_lp_base)]   <= w_cnt_in;
            end
        end
    end

    assign faddr     = r_faddr;
    assign pm_cslt   = !r_idle & !r_halt;
    assign pcstk_top = w_pc_top;
    assign pcstk_ptr = r_pc_ptr;
    assign lp_lvl    = r_lp_lvl;
    assign lp_curcnt = w_lp_cnt_top;
    assign stcky     = {r_lp_ovf, w_lp_full, w_lp_empty, r_pc_uo, w_pc_full, w_pc_empty};
endmodule

// File: tb/tb_ps_fetch_seq.sv
// tb_ps_fetch_seq: directed tables, corner sequences and random stimulus against a queue-based model of ps_fetch_seq
module tb_ps_fetch_seq;
    localparam int PD = 8;
    localparam int LD = 4;

    logic        clk_fetch = 1'b0;
    logic        rst = 1'b0;
    logic        stallb, jmp_req, call_req, rtrn_req, push_req, pop_req, loop_req, idle_req, interrupt;
    logic [15:0] tgt_addr, push_data, loop_end, loop_cnt;
    logic [15:0] faddr, pcstk_top, lp_curcnt;
    logic        pm_cslt;
    logic [3:0]  pcstk_ptr;
    logic [2:0]  lp_lvl;
    logic [5:0]  stcky;

    ps_fetch_seq dut (
        .clk_fetch(clk_fetch), .rst(rst), .stallb(stallb), .jmp_req(jmp_req), .call_req(call_req),
        .tgt_addr(tgt_addr), .rtrn_req(rtrn_req), .push_req(push_req), .pop_req(pop_req),
        .push_data(push_data), .loop_req(loop_req), .loop_end(loop_end), .loop_cnt(loop_cnt),
        .idle_req(idle_req), .interrupt(interrupt), .faddr(faddr), .pm_cslt(pm_cslt),
        .pcstk_top(pcstk_top), .pcstk_ptr(pcstk_ptr), .lp_lvl(lp_lvl), .lp_curcnt(lp_curcnt),
        .stcky(stcky)
    );

    always #5 clk_fetch = ~clk_fetch;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        stallb, jmp, call, rtrn, push, pop, loop, idle, intr;
        logic [15:0] tgt, pdata, lend, lcnt;
        logic [15:0] e_faddr, e_top, e_cnt;
        logic        e_cslt;
        int          e_ptr, e_lvl;
    } vec_t;
    vec_t tab[$];

    typedef struct { logic [15:0] s, e, c; } lp_t;
    logic [15:0] m_faddr;
    logic [15:0] m_pc[$];
    lp_t         m_lp[$];
    logic        m_idle, m_halt, m_pcuo, m_lpovf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_faddr = 0;
        m_pc = {};
        m_lp = {};
        m_idle = 0;
        m_halt = 0;
        m_pcuo = 0;
        m_lpovf = 0;
    endtask

    task automatic pc_push(input logic [15:0] d);
        if (m_pc.size() == PD) begin
            m_pcuo = 1;
            m_halt = 1;
        end else m_pc.push_back(d);
    endtask

    // One clock of the sequencer as described by its rules, using queues for both stacks.
    task automatic model_update();
        logic        nidle;
        logic [15:0] nf;
        if (!stallb) return;
        nidle = !interrupt && (m_idle || (idle_req && !m_halt));
        if (!m_idle && !m_halt) begin
            nf = m_faddr + 16'd1;
            if (jmp_req || call_req) nf = tgt_addr;
            else if (rtrn_req) begin
                if (m_pc.size() > 0) nf = m_pc[$];
            end else if (m_lp.size() > 0 && m_faddr == m_lp[$].e) begin
                if (m_lp[$].c > 1) begin
                    nf = m_lp[$].s;
                    m_lp[m_lp.size()-1].c = m_lp[$].c - 16'd1;
                end else void'(m_lp.pop_back());
            end
            if (call_req) pc_push(m_faddr);
            else if (push_req && !(rtrn_req || pop_req)) pc_push(push_data);
            else if (!push_req && (rtrn_req || pop_req)) begin
                if (m_pc.size() == 0) m_pcuo = 1;
                else void'(m_pc.pop_back());
            end
            if (loop_req) begin
                if (m_lp.size() == LD) begin
                    m_lpovf = 1;
                    m_halt = 1;
                end else m_lp.push_back('{m_faddr, loop_end, (loop_cnt == 0) ? 16'd1 : loop_cnt});
            end
            m_faddr = nf;
        end
        m_idle = nidle;
    endtask

    task automatic cmp_model(input string tag);
        logic [5:0] es;
        es = {m_lpovf, m_lp.size() == LD, m_lp.size() == 0, m_pcuo, m_pc.size() == PD, m_pc.size() == 0};
        chk({tag, " faddr"}, 32'(faddr), 32'(m_faddr));
        chk({tag, " pm_cslt"}, 32'(pm_cslt), 32'(!m_idle && !m_halt));
        chk({tag, " pcstk_top"}, 32'(pcstk_top), (m_pc.size() > 0) ? 32'(m_pc[$]) : 0);
        chk({tag, " pcstk_ptr"}, 32'(pcstk_ptr), 32'(m_pc.size()));
        chk({tag, " lp_lvl"}, 32'(lp_lvl), 32'(m_lp.size()));
        chk({tag, " lp_curcnt"}, 32'(lp_curcnt), (m_lp.size() > 0) ? 32'(m_lp[$].c) : 0);
        chk({tag, " stcky"}, 32'(stcky), 32'(es));
    endtask

    task automatic clear_in();
        stallb = 1; jmp_req = 0; call_req = 0; rtrn_req = 0; push_req = 0; pop_req = 0;
        loop_req = 0; idle_req = 0; interrupt = 0;
        tgt_addr = 0; push_data = 0; loop_end = 0; loop_cnt = 0;
    endtask

    task automatic step(input string tag);
        model_update();
        @(posedge clk_fetch);
        #1;
        cmp_model(tag);
    endtask

    task automatic do_reset();
        rst = 0;
        clear_in();
        @(posedge clk_fetch);
        #1;
        rst = 1;
        model_reset();
    endtask

    task automatic run_free(input int n);
        clear_in();
        repeat (n) step("free");
    endtask

    function automatic vec_t v(input string op, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] ef, input logic ecs, input int ep,
                               input logic [15:0] et, input int el, input logic [15:0] ec);
        vec_t r;
        r = '{stallb: 1, jmp: 0, call: 0, rtrn: 0, push: 0, pop: 0, loop: 0, idle: 0, intr: 0,
              tgt: 0, pdata: 0, lend: 0, lcnt: 0, e_faddr: ef, e_top: et, e_cnt: ec,
              e_cslt: ecs, e_ptr: ep, e_lvl: el};
        if (op == "call") begin r.call = 1; r.tgt = a; end
        else if (op == "jmp") begin r.jmp = 1; r.tgt = a; end
        else if (op == "rtrn") r.rtrn = 1;
        else if (op == "push") begin r.push = 1; r.pdata = a; end
        else if (op == "pop") r.pop = 1;
        else if (op == "loop") begin r.loop = 1; r.lend = a; r.lcnt = b; end
        else if (op == "stall") r.stallb = 0;
        else if (op == "idle") r.idle = 1;
        else if (op == "intr") r.intr = 1;
        return r;
    endfunction

    task automatic run_tab(input string nm);
        string t;
        for (int i = 0; i < tab.size(); i++) begin
            t = $sformatf("%s[%0d]", nm, i);
            stallb = tab[i].stallb; jmp_req = tab[i].jmp; call_req = tab[i].call;
            rtrn_req = tab[i].rtrn; push_req = tab[i].push; pop_req = tab[i].pop;
            loop_req = tab[i].loop; idle_req = tab[i].idle; interrupt = tab[i].intr;
            tgt_addr = tab[i].tgt; push_data = tab[i].pdata; loop_end = tab[i].lend; loop_cnt = tab[i].lcnt;
            step(t);
            chk({t, " tab faddr"}, 32'(faddr), 32'(tab[i].e_faddr));
            chk({t, " tab cslt"}, 32'(pm_cslt), 32'(tab[i].e_cslt));
            chk({t, " tab ptr"}, 32'(pcstk_ptr), 32'(tab[i].e_ptr));
            chk({t, " tab top"}, 32'(pcstk_top), 32'(tab[i].e_top));
            chk({t, " tab lvl"}, 32'(lp_lvl), 32'(tab[i].e_lvl));
            chk({t, " tab cnt"}, 32'(lp_curcnt), 32'(tab[i].e_cnt));
            clear_in();
        end
        tab = {};
    endtask

    initial begin
        logic [15:0] nest_exp[18];
        logic        outer_done;
        nest_exp = '{26, 27, 28, 26, 27, 28, 29, 30, 25, 26, 27, 28, 26, 27, 28, 29, 30, 31};

        // Reset values, then free-running increment.
        do_reset();
        cmp_model("reset");
        chk("reset faddr", 32'(faddr), 0);
        chk("reset cslt", 32'(pm_cslt), 1);
        chk("reset stcky", 32'(stcky), 32'(6'b001001));
        for (int i = 1; i <= 5; i++) begin
            step("count");
            chk($sformatf("count faddr %0d", i), 32'(faddr), 32'(i));
        end

        // Call from 10 to 40, return at 43 back to 10.
        run_free(5);
        tab.push_back(v("call", 40, 0, 40, 1, 1, 10, 0, 0));
        tab.push_back(v("none", 0, 0, 41, 1, 1, 10, 0, 0));
        tab.push_back(v("none", 0, 0, 42, 1, 1, 10, 0, 0));
        tab.push_back(v("none", 0, 0, 43, 1, 1, 10, 0, 0));
        tab.push_back(v("rtrn", 0, 0, 10, 1, 0, 0, 0, 0));
        tab.push_back(v("none", 0, 0, 11, 1, 0, 0, 0, 0));
        run_tab("callret");

        // Single loop at 20..22, three iterations.
        do_reset();
        run_free(20);
        tab.push_back(v("loop", 22, 3, 21, 1, 0, 0, 1, 3));
        tab.push_back(v("none", 0, 0, 22, 1, 0, 0, 1, 3));
        tab.push_back(v("none", 0, 0, 20, 1, 0, 0, 1, 2));
        tab.push_back(v("none", 0, 0, 21, 1, 0, 0, 1, 2));
        tab.push_back(v("none", 0, 0, 22, 1, 0, 0, 1, 2));
        tab.push_back(v("none", 0, 0, 20, 1, 0, 0, 1, 1));
        tab.push_back(v("none", 0, 0, 21, 1, 0, 0, 1, 1));
        tab.push_back(v("none", 0, 0, 22, 1, 0, 0, 1, 1));
        tab.push_back(v("none", 0, 0, 23, 1, 0, 0, 0, 0));
        tab.push_back(v("none", 0, 0, 24, 1, 0, 0, 0, 0));
        run_tab("loop1");

        // Stall and idle in the middle of a loop; the loop resumes exactly.
        do_reset();
        run_free(20);
        tab.push_back(v("loop", 22, 3, 21, 1, 0, 0, 1, 3));
        tab.push_back(v("none", 0, 0, 22, 1, 0, 0, 1, 3));
        tab.push_back(v("stall", 0, 0, 22, 1, 0, 0, 1, 3));
        tab.push_back(v("stall", 0, 0, 22, 1, 0, 0, 1, 3));
        tab.push_back(v("stall", 0, 0, 22, 1, 0, 0, 1, 3));
        tab.push_back(v("none", 0, 0, 20, 1, 0, 0, 1, 2));
        tab.push_back(v("idle", 0, 0, 21, 0, 0, 0, 1, 2));
        tab.push_back(v("jmp", 99, 0, 21, 0, 0, 0, 1, 2));
        tab.push_back(v("loop", 50, 5, 21, 0, 0, 0, 1, 2));
        tab.push_back(v("intr", 0, 0, 21, 1, 0, 0, 1, 2));
        tab.push_back(v("none", 0, 0, 22, 1, 0, 0, 1, 2));
        tab.push_back(v("none", 0, 0, 20, 1, 0, 0, 1, 1));
        tab.push_back(v("none", 0, 0, 21, 1, 0, 0, 1, 1));
        tab.push_back(v("none", 0, 0, 22, 1, 0, 0, 1, 1));
        tab.push_back(v("none", 0, 0, 23, 1, 0, 0, 0, 0));
        run_tab("stallidle");

        // Zero count behaves as one; address wraps at 2^16.
        do_reset();
        tab.push_back(v("loop", 1, 0, 1, 1, 0, 0, 1, 1));
        tab.push_back(v("none", 0, 0, 2, 1, 0, 0, 0, 0));
        tab.push_back(v("jmp", 16'hffff, 0, 16'hffff, 1, 0, 0, 0, 0));
        tab.push_back(v("none", 0, 0, 0, 1, 0, 0, 0, 0));
        run_tab("cnt0wrap");

        // Nested loops: outer 25..30 x2, inner 26..28 x2, reopened on each outer pass.
        do_reset();
        run_free(25);
        outer_done = 0;
        for (int i = 0; i < 18; i++) begin
            clear_in();
            if (m_faddr == 25 && !outer_done) begin
                loop_req = 1; loop_end = 30; loop_cnt = 2; outer_done = 1;
            end else if (m_faddr == 26 && m_lp.size() == 1) begin
                loop_req = 1; loop_end = 28; loop_cnt = 2;
            end
            step("nest");
            chk($sformatf("nest faddr %0d", i), 32'(faddr), 32'(nest_exp[i]));
        end
        clear_in();

        // PC stack overflow halts fetch until reset; reset is asynchronous.
        do_reset();
        for (int i = 0; i < PD; i++) begin
            push_req = 1; push_data = 16'(100 + i);
            step("push");
        end
        chk("full ptr", 32'(pcstk_ptr), 8);
        chk("full stcky", 32'(stcky), 32'(6'b001010));
        push_req = 1; push_data = 16'h0bad;
        step("ovf");
        chk("ovf ptr", 32'(pcstk_ptr), 8);
        chk("ovf stcky21", 32'(stcky[2:1]), 3);
        chk("ovf cslt", 32'(pm_cslt), 0);
        chk("ovf top", 32'(pcstk_top), 107);
        clear_in();
        for (int i = 0; i < 3; i++) begin
            jmp_req = 1; tgt_addr = 16'h0055;
            step("halted");
            chk("halted faddr", 32'(faddr), 9);
        end
        clear_in();
        #2;
        rst = 0;
        #1;
        chk("async faddr", 32'(faddr), 0);
        chk("async stcky", 32'(stcky), 32'(6'b001001));
        chk("async cslt", 32'(pm_cslt), 1);
        chk("async ptr", 32'(pcstk_ptr), 0);
        do_reset();

        // Underflow is sticky but does not halt.
        pop_req = 1;
        step("unf pop");
        chk("unf pop faddr", 32'(faddr), 1);
        chk("unf stcky", 32'(stcky), 32'(6'b001101));
        clear_in();
        rtrn_req = 1;
        step("unf rtrn");
        chk("unf rtrn faddr", 32'(faddr), 2);
        chk("unf cslt", 32'(pm_cslt), 1);
        clear_in();

        // Loop stack overflow.
        do_reset();
        for (int i = 0; i < LD; i++) begin
            loop_req = 1; loop_end = 16'd1000; loop_cnt = 2;
            step("lpush");
        end
        chk("lp full lvl", 32'(lp_lvl), 4);
        chk("lp full stcky", 32'(stcky), 32'(6'b010001));
        step("lp ovf");
        chk("lp ovf lvl", 32'(lp_lvl), 4);
        chk("lp ovf stcky", 32'(stcky), 32'(6'b110001));
        chk("lp ovf cslt", 32'(pm_cslt), 0);
        clear_in();

        // Random stimulus against the model.
        do_reset();
        for (int n = 0; n < 2500; n++) begin
            if (m_halt || (n % 180) == 179) do_reset();
            stallb    = $urandom_range(9) != 0;
            jmp_req   = $urandom_range(15) == 0;
            call_req  = $urandom_range(11) == 0;
            rtrn_req  = $urandom_range(9) == 0;
            push_req  = $urandom_range(11) == 0;
            pop_req   = $urandom_range(13) == 0;
            loop_req  = $urandom_range(9) == 0;
            idle_req  = $urandom_range(39) == 0;
            interrupt = $urandom_range(3) == 0;
            tgt_addr  = 16'($urandom_range(63));
            push_data = 16'($urandom);
            loop_end  = m_faddr + 16'($urandom_range(4));
            loop_cnt  = 16'($urandom_range(3));
            step("rand");
        end
        clear_in();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
